// File: rtl/game2048_pkg.sv
// Shared constants, FSM state type and LFSR helper for the 2048 board logic.
// Imported by lfsr16 and tile_spawner.
package game2048_pkg;

  localparam int N      = 4;
  localparam int TILE_W = 4;
  localparam int CELLS  = N * N;
  localparam int IDX_W  = $clog2(CELLS);

  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  // An all-zero LFSR state would lock up, so it is mapped to LFSR_RESET.
  function automatic logic [15:0] lfsr_fix(input logic [15:0] v);
    return (v == 16'h0) ? LFSR_RESET : v;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with zero guard.
// Ports: clk, rst (sync, active high), load/load_val (override step), q.
module lfsr16
  import game2048_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
  assign q    = r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= lfsr_fix(SEED);
    end else if (load) begin
      r_q <= lfsr_fix(load_val);
    end else begin
      r_q <= lfsr_fix({r_q[14:0], w_fb});
    end
  end

endmodule

// File: rtl/tile_spawner.sv
// New-tile generator: snapshots the board, scans from an LFSR-chosen cell
// with wrap-around for an empty slot and writes a 2 or 4 tile there.
// Ports: clk, rst (sync, active high), spawn_req, in_vals -> out_vals,
// busy (scanning), done (result pulse), full (no empty cell, with done).
// Optional macro TILE_SPAWN_SEED_PORT_EN adds seed_we/seed to reload LFSR.
module tile_spawner
  import game2048_pkg::*;
#(
  parameter int          N          = game2048_pkg::N,
  parameter int          TILE_W     = game2048_pkg::TILE_W,
  parameter int          TWO_THRESH = 11,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         CELLS      = N * N,
  localparam int         IDX_W      = $clog2(CELLS),
  localparam int         BW         = CELLS * TILE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spawn_req,
  input  logic [BW-1:0] in_vals,
`ifdef TILE_SPAWN_SEED_PORT_EN
  input  logic          seed_we,
  input  logic [15:0]   seed,
`endif
  output logic [BW-1:0] out_vals,
  output logic          busy,
  output logic          done,
  output logic          full
);

  state_t              r_state;
  state_t              w_state_nx;
  logic [BW-1:0]       r_snap;
  logic [BW-1:0]       r_out;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W:0]      r_cnt;
  logic [TILE_W-1:0]   r_val;
  logic                r_done;
  logic                r_full;

  logic [15:0]         w_lfsr;
  logic                w_load;
  logic [15:0]         w_load_val;
  logic [TILE_W-1:0]   w_cell;
  logic [TILE_W-1:0]   w_code;
  logic [BW-1:0]       w_put;
  logic                w_start;
  logic                w_exh;
  logic                w_empty;

`ifdef TILE_SPAWN_SEED_PORT_EN
  assign w_load     = seed_we;
  assign w_load_val = seed;
`else
  assign w_load     = 1'b0;
  assign w_load_val = 16'h0;
`endif

  lfsr16 #(
    .SEED    (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .load_val(w_load_val),
    .q       (w_lfsr)
  );

  assign w_cell  = r_snap[r_ptr*TILE_W +: TILE_W];
  assign w_start = (r_state == IDLE) && spawn_req;
  assign w_exh   = (r_cnt == (IDX_W+1)'(CELLS));
  assign w_empty = (w_cell == '0);
  assign w_code  = (5'(w_lfsr[15:12]) < 5'(TWO_THRESH))
                 ? TILE_W'(1) : TILE_W'(2);

  always_comb begin
    w_put = r_snap;
    w_put[r_ptr*TILE_W +: TILE_W] = r_val;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (1'b1)
      (r_state == IDLE): if (spawn_req) w_state_nx = SCAN;
      (r_state == SCAN): if (w_exh || w_empty) w_state_nx = IDLE;
      default:           w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_out   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_val   <= '0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= 1'b0;
      if (w_start) begin
        r_snap <= in_vals;
        r_ptr  <= w_lfsr[IDX_W-1:0];
        r_val  <= w_code;
        r_cnt  <= '0;
      end else if (r_state == SCAN) begin
        if (w_exh) begin
          r_out  <= r_snap;
          r_full <= 1'b1;
          r_done <= 1'b1;
        end else if (w_empty) begin
          r_out  <= w_put;
          r_full <= 1'b0;
          r_done <= 1'b1;
        end else begin
          // CELLS is a power of two, so the increment wraps by itself.
          r_ptr <= r_ptr + 1'b1;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign out_vals = r_out;
  assign busy     = (r_state == SCAN);
  assign done     = r_done;
  assign full     = r_full;

endmodule
